// File: rtl/fifo_ptr_ctrl_pkg.sv
// Shared types, defaults and gray helper for the FIFO pointer controller.
package fifo_pkg;

   localparam int unsigned FIFO_NUM_BITS = 4;
   localparam int unsigned FIFO_AF_LEVEL = 14;
   localparam int unsigned FIFO_AE_LEVEL = 2;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } fifo_flags_t;

   localparam fifo_flags_t FIFO_FLAGS_RST = '{
      full:         1'b0,
      empty:        1'b1,
      almost_full:  1'b0,
      almost_empty: 1'b1
   };

   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/fifo_ptr_ctrl_if.sv
// Producer/consumer/RAM-side signal bundle of fifo_ptr_ctrl.
// FIFO_PTR_CTRL_ERR_EN adds sticky overflow/underflow.
interface fifo_ptr_ctrl_if #(
   parameter int unsigned NUM_BITS = fifo_pkg::FIFO_NUM_BITS
);

   logic                wr_req;
   logic                rd_req;
   logic                mem_we;
   logic [NUM_BITS-1:0] mem_waddr;
   logic                mem_re;
   logic [NUM_BITS-1:0] mem_raddr;
   logic                rd_valid;
   logic                full;
   logic                empty;
   logic                almost_full;
   logic                almost_empty;
   logic [NUM_BITS:0]   count;
   logic [NUM_BITS:0]   wr_gray;
   logic [NUM_BITS:0]   rd_gray;
`ifdef FIFO_PTR_CTRL_ERR_EN
   logic                overflow;
   logic                underflow;

   modport master (
      output wr_req, rd_req,
      input  mem_we, mem_waddr, mem_re, mem_raddr, rd_valid, full, empty,
             almost_full, almost_empty, count, wr_gray, rd_gray, overflow, underflow
   );

   modport slave (
      input  wr_req, rd_req,
      output mem_we, mem_waddr, mem_re, mem_raddr, rd_valid, full, empty,
             almost_full, almost_empty, count, wr_gray, rd_gray, overflow, underflow
   );
`else
   modport master (
      output wr_req, rd_req,
      input  mem_we, mem_waddr, mem_re, mem_raddr, rd_valid, full, empty,
             almost_full, almost_empty, count, wr_gray, rd_gray
   );

   modport slave (
      input  wr_req, rd_req,
      output mem_we, mem_waddr, mem_re, mem_raddr, rd_valid, full, empty,
             almost_full, almost_empty, count, wr_gray, rd_gray
   );
`endif

endinterface

// File: rtl/fifo_ptr_ctrl_ptr.sv
// NUM_BITS+1 binary pointer with gray shadow; exposes next-state and registered values.
module fifo_ptr
   import fifo_pkg::*;
#(
   parameter int unsigned NUM_BITS = FIFO_NUM_BITS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   output logic [NUM_BITS:0] bin_next,
   output logic [NUM_BITS:0] gray_next,
   output logic [NUM_BITS:0] bin,
   output logic [NUM_BITS:0] gray
);

   localparam int unsigned PtrW = NUM_BITS + 1;

   logic [NUM_BITS:0] bin_d, bin_q;
   logic [NUM_BITS:0] gray_d, gray_q;

   // Gray is derived from next-state binary so both registers stay coherent.
   always_comb begin
      bin_d = bin_q;
      if (inc) begin
         bin_d = bin_q + 1'b1;
      end
      gray_d = PtrW'(bin2gray(32'(bin_d)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q  <= '0;
         gray_q <= '0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
      end
   end

   assign bin_next  = bin_d;
   assign gray_next = gray_d;
   assign bin       = bin_q;
   assign gray      = gray_q;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Single-clock FIFO pointer/flag controller for a sync-read dual-port buffer RAM.
// FIFO_PTR_CTRL_ERR_EN adds sticky overflow/underflow outputs.
module fifo_ptr_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned NUM_BITS = FIFO_NUM_BITS,
   parameter int unsigned AF_LEVEL = FIFO_AF_LEVEL,
   parameter int unsigned AE_LEVEL = FIFO_AE_LEVEL
) (
   input  logic           clk,
   input  logic           rst,
   fifo_ptr_ctrl_if.slave bus
);

   localparam int unsigned       PtrW  = NUM_BITS + 1;
   localparam logic [NUM_BITS:0] AfLvl = PtrW'(AF_LEVEL);
   localparam logic [NUM_BITS:0] AeLvl = PtrW'(AE_LEVEL);

   logic              wr_inc, rd_inc;
   logic [NUM_BITS:0] wr_bin_next, wr_gray_next, wr_bin, wr_gray;
   logic [NUM_BITS:0] rd_bin_next, rd_gray_next, rd_bin, rd_gray;
   logic [NUM_BITS:0] count_d, count_q;
   fifo_flags_t       flags_d, flags_q;
   logic              rd_valid_d, rd_valid_q;
   logic              unused_ptr_msb;

   // Acceptance uses registered flags only: no bypass when full or empty.
   assign wr_inc = bus.wr_req & ~flags_q.full;
   assign rd_inc = bus.rd_req & ~flags_q.empty;

   fifo_ptr #(
      .NUM_BITS (NUM_BITS)
   ) u_wr_ptr (
      .clk       (clk),
      .rst       (rst),
      .inc       (wr_inc),
      .bin_next  (wr_bin_next),
      .gray_next (wr_gray_next),
      .bin       (wr_bin),
      .gray      (wr_gray)
   );

   fifo_ptr #(
      .NUM_BITS (NUM_BITS)
   ) u_rd_ptr (
      .clk       (clk),
      .rst       (rst),
      .inc       (rd_inc),
      .bin_next  (rd_bin_next),
      .gray_next (rd_gray_next),
      .bin       (rd_bin),
      .gray      (rd_gray)
   );

   always_comb begin
      count_d              = wr_bin_next - rd_bin_next;
      flags_d.empty        = (wr_gray_next == rd_gray_next);
      // Full in gray: top two bits inverted, remainder equal.
      flags_d.full         = (wr_gray_next == {~rd_gray_next[NUM_BITS -: 2],
                                               rd_gray_next[NUM_BITS-2:0]});
      flags_d.almost_full  = (count_d >= AfLvl);
      flags_d.almost_empty = (count_d <= AeLvl);
      rd_valid_d           = rd_inc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q    <= '0;
         flags_q    <= FIFO_FLAGS_RST;
         rd_valid_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         flags_q    <= flags_d;
         rd_valid_q <= rd_valid_d;
      end
   end

`ifdef FIFO_PTR_CTRL_ERR_EN
   logic ovf_d, ovf_q;
   logic udf_d, udf_q;

   always_comb begin
      ovf_d = ovf_q | (bus.wr_req & flags_q.full);
      udf_d = udf_q | (bus.rd_req & flags_q.empty);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign bus.overflow  = ovf_q;
   assign bus.underflow = udf_q;
`endif

   assign bus.mem_we       = wr_inc;
   assign bus.mem_waddr    = wr_bin[NUM_BITS-1:0];
   assign bus.mem_re       = rd_inc;
   assign bus.mem_raddr    = rd_bin[NUM_BITS-1:0];
   assign bus.rd_valid     = rd_valid_q;
   assign bus.full         = flags_q.full;
   assign bus.empty        = flags_q.empty;
   assign bus.almost_full  = flags_q.almost_full;
   assign bus.almost_empty = flags_q.almost_empty;
   assign bus.count        = count_q;
   assign bus.wr_gray      = wr_gray;
   assign bus.rd_gray      = rd_gray;

   // Pointer wrap bits only matter through the gray/count paths.
   assign unused_ptr_msb = wr_bin[NUM_BITS] ^ rd_bin[NUM_BITS];

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed self-checking bench for fifo_ptr_ctrl (default depth 16, AF 14, AE 2).
module tb_fifo_ptr_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   fifo_ptr_ctrl_if #(.NUM_BITS(4)) bus ();

   fifo_ptr_ctrl #(
      .NUM_BITS (4),
      .AF_LEVEL (14),
      .AE_LEVEL (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Inputs change after the falling edge; registered outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
      tick();
      tick();
      total++;
      if (bus.empty !== 1'b1 || bus.almost_empty !== 1'b1) begin
         bad++;
         $display("FAIL reset_empty got=%b/%b exp=1/1", bus.empty, bus.almost_empty);
      end
      total++;
      if (bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin
         bad++;
         $display("FAIL reset_full got=%b/%b exp=0/0", bus.full, bus.almost_full);
      end
      total++;
      if (bus.count !== 5'd0 || bus.rd_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_count got=%0d rv=%b exp=0 rv=0", bus.count, bus.rd_valid);
      end
      total++;
      if (bus.wr_gray !== 5'd0 || bus.rd_gray !== 5'd0) begin
         bad++;
         $display("FAIL reset_gray got=%b/%b exp=00000/00000", bus.wr_gray, bus.rd_gray);
      end
      rst = 1'b0;
   endtask

   task automatic test_fill();
      logic       exp_af, exp_ae, exp_full;
      logic [4:0] exp_cnt;
      for (int k = 0; k < 16; k++) begin
         bus.wr_req = 1'b1;
         #1;
         total++;
         if (bus.mem_we !== 1'b1 || bus.mem_waddr !== 4'(k)) begin
            bad++;
            $display("FAIL fill_we[%0d] got we=%b addr=%0d exp we=1 addr=%0d",
                     k, bus.mem_we, bus.mem_waddr, k);
         end
         tick();
         exp_cnt  = 5'(k + 1);
         exp_af   = (k + 1 >= 14);
         exp_ae   = (k + 1 <= 2);
         exp_full = (k == 15);
         total++;
         if (bus.count !== exp_cnt || bus.almost_full !== exp_af || bus.full !== exp_full ||
             bus.empty !== 1'b0 || bus.almost_empty !== exp_ae) begin
            bad++;
            $display("FAIL fill_flags[%0d] got cnt=%0d af=%b f=%b e=%b ae=%b exp cnt=%0d af=%b f=%b e=0 ae=%b",
                     k, bus.count, bus.almost_full, bus.full, bus.empty, bus.almost_empty,
                     exp_cnt, exp_af, exp_full, exp_ae);
         end
      end
      #1;
      total++;
      if (bus.mem_we !== 1'b0) begin
         bad++;
         $display("FAIL fill_17th_we got=%b exp=0", bus.mem_we);
      end
      tick();
      total++;
      if (bus.wr_gray !== 5'b11000 || bus.count !== 5'd16 || bus.full !== 1'b1) begin
         bad++;
         $display("FAIL fill_held got gray=%b cnt=%0d f=%b exp gray=11000 cnt=16 f=1",
                  bus.wr_gray, bus.count, bus.full);
      end
`ifdef FIFO_PTR_CTRL_ERR_EN
      total++;
      if (bus.overflow !== 1'b1) begin
         bad++;
         $display("FAIL overflow_set got=%b exp=1", bus.overflow);
      end
`endif
      bus.wr_req = 1'b0;
   endtask

   task automatic test_drain();
      for (int k = 0; k < 16; k++) begin
         bus.rd_req = 1'b1;
         #1;
         total++;
         if (bus.mem_re !== 1'b1 || bus.mem_raddr !== 4'(k)) begin
            bad++;
            $display("FAIL drain_re[%0d] got re=%b addr=%0d exp re=1 addr=%0d",
                     k, bus.mem_re, bus.mem_raddr, k);
         end
         tick();
         total++;
         if (bus.rd_valid !== 1'b1 || bus.count !== 5'(15 - k) || bus.empty !== (k == 15)) begin
            bad++;
            $display("FAIL drain_state[%0d] got rv=%b cnt=%0d e=%b exp rv=1 cnt=%0d e=%b",
                     k, bus.rd_valid, bus.count, bus.empty, 15 - k, (k == 15));
         end
      end
      #1;
      total++;
      if (bus.mem_re !== 1'b0) begin
         bad++;
         $display("FAIL drain_17th_re got=%b exp=0", bus.mem_re);
      end
      tick();
      total++;
      if (bus.rd_valid !== 1'b0 || bus.empty !== 1'b1 || bus.rd_gray !== 5'b11000) begin
         bad++;
         $display("FAIL drain_held got rv=%b e=%b gray=%b exp rv=0 e=1 gray=11000",
                  bus.rd_valid, bus.empty, bus.rd_gray);
      end
`ifdef FIFO_PTR_CTRL_ERR_EN
      total++;
      if (bus.underflow !== 1'b1) begin
         bad++;
         $display("FAIL underflow_set got=%b exp=1", bus.underflow);
      end
`endif
      bus.rd_req = 1'b0;
   endtask

   task automatic test_simultaneous();
      logic [4:0] pw, pr;
      bus.wr_req = 1'b1;
      repeat (8) tick();
      total++;
      if (bus.count !== 5'd8) begin
         bad++;
         $display("FAIL simul_pre_count got=%0d exp=8", bus.count);
      end
      bus.rd_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         total++;
         if (bus.mem_waddr !== 4'((8 + i) % 16) || bus.mem_raddr !== 4'(i % 16)) begin
            bad++;
            $display("FAIL simul_addr[%0d] got wa=%0d ra=%0d exp wa=%0d ra=%0d",
                     i, bus.mem_waddr, bus.mem_raddr, (8 + i) % 16, i % 16);
         end
         pw = bus.wr_gray;
         pr = bus.rd_gray;
         tick();
         total++;
         if (bus.count !== 5'd8 || $countones(bus.wr_gray ^ pw) != 1 ||
             $countones(bus.rd_gray ^ pr) != 1) begin
            bad++;
            $display("FAIL simul_step[%0d] got cnt=%0d wg=%b->%b rg=%b->%b exp cnt=8 one-bit steps",
                     i, bus.count, pw, bus.wr_gray, pr, bus.rd_gray);
         end
      end
      bus.rd_req = 1'b0;
   endtask

   task automatic test_full_read();
      repeat (8) tick();
      total++;
      if (bus.full !== 1'b1 || bus.count !== 5'd16) begin
         bad++;
         $display("FAIL fr_pre got f=%b cnt=%0d exp f=1 cnt=16", bus.full, bus.count);
      end
      bus.rd_req = 1'b1;
      #1;
      total++;
      if (bus.mem_we !== 1'b0 || bus.mem_re !== 1'b1) begin
         bad++;
         $display("FAIL fr_strobes got we=%b re=%b exp we=0 re=1", bus.mem_we, bus.mem_re);
      end
      tick();
      total++;
      if (bus.count !== 5'd15 || bus.full !== 1'b0) begin
         bad++;
         $display("FAIL fr_after_read got cnt=%0d f=%b exp cnt=15 f=0", bus.count, bus.full);
      end
      bus.rd_req = 1'b0;
      #1;
      total++;
      if (bus.mem_we !== 1'b1) begin
         bad++;
         $display("FAIL fr_retry_we got=%b exp=1", bus.mem_we);
      end
      tick();
      total++;
      if (bus.count !== 5'd16 || bus.full !== 1'b1) begin
         bad++;
         $display("FAIL fr_refull got cnt=%0d f=%b exp cnt=16 f=1", bus.count, bus.full);
      end
      bus.wr_req = 1'b0;
   endtask

   task automatic test_reset_midop();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.wr_req = 1'b1;
      repeat (5) tick();
      total++;
      if (bus.count !== 5'd5) begin
         bad++;
         $display("FAIL rst_mid_pre got cnt=%0d exp=5", bus.count);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.wr_req = 1'b0;
      #1;
      total++;
      if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.mem_waddr !== 4'd0 ||
          bus.mem_raddr !== 4'd0 || bus.wr_gray !== 5'd0) begin
         bad++;
         $display("FAIL rst_mid got cnt=%0d e=%b wa=%0d ra=%0d wg=%b exp 0 1 0 0 00000",
                  bus.count, bus.empty, bus.mem_waddr, bus.mem_raddr, bus.wr_gray);
      end
`ifdef FIFO_PTR_CTRL_ERR_EN
      total++;
      if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_err got ovf=%b udf=%b exp 0/0", bus.overflow, bus.underflow);
      end
`endif
   endtask

   initial begin
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
      @(negedge clk);
      test_reset();
      test_fill();
      test_drain();
      test_simultaneous();
      test_full_read();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
